// File: rtl/hazard_forward_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl_if
// Bundle between the ID/EX pipeline logic and the hazard/forwarding
// controller.
//   master : pipeline side. It drives the ID instruction info and the EX
//            branch outcome, and receives the operand selects and the
//            stall/flush controls.
//   slave  : controller side.
// Optional macro HAZARD_PERF_CNT_EN adds the CNT_W parameter and the
// stall_cnt/flush_cnt counter outputs.
// ---------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  // ID-stage instruction info
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  // EX-stage branch outcome
  logic                  ex_branch_taken;
  // Controller outputs
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  pc_hold;
  logic                  ifid_hold;
  logic                  idex_bubble;
  logic                  ifid_flush;
  logic [1:0]            ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold,
           idex_bubble, ifid_flush, ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_regwrite, id_memread, ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold,
           idex_bubble, ifid_flush, ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// The block is clocked with the ID/EX register. It tracks the destination
// info of the instructions now in EX and MEM, and it produces:
//   - registered operand selects fwd_a_sel/fwd_b_sel for the EX instruction.
//     The encoding is 00 = ID/EX value, 01 = MEM/WB result, 10 = EX/MEM
//     result. The code 11 is never driven.
//   - combinational load-use stall controls: pc_hold, ifid_hold, idex_bubble.
//   - combinational taken-branch flush controls: ifid_flush, idex_bubble.
//   - ctrl_state, a debug copy of last cycle's action (RUN/STALL/FLUSH).
// Ports:
//   clk, rst_n : pipeline clock, asynchronous active-low reset.
//   bus        : hazard_forward_ctrl_if.slave (ID info in, controls out).
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
//
// The WB stage moves down the same shadow pipeline. It is not held as a
// register, because nothing reads it: the register file writes in the first
// half-cycle, so a WB result is already visible to ID and needs no forward.
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_IDEX  = 2'b00,
    SEL_MEMWB = 2'b01,
    SEL_EXMEM = 2'b10
  } sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  slot_t  ex_slot, mem_slot;
  state_t state;
  sel_t   fwd_a_q, fwd_b_q;
  sel_t   fwd_a_nxt, fwd_b_nxt;
  logic   load_use, flush, stall;

  // A slot produces r when it writes r. Register 0 is hard-wired and never
  // counts as a match.
  function automatic logic produces(input slot_t s,
                                    input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

  // A load in EX has no data yet, so it cannot forward from EX/MEM. It
  // becomes a MEM/WB forward one cycle later, after the stall.
  function automatic sel_t pick_src(input logic use_op,
                                    input logic [REG_ADDR_W-1:0] r,
                                    input slot_t ex, input slot_t mem);
    if (!use_op)                          return SEL_IDEX;
    else if (produces(ex, r) && !ex.memread) return SEL_EXMEM;
    else if (produces(mem, r))            return SEL_MEMWB;
    else                                  return SEL_IDEX;
  endfunction

  // NOTE: every always_comb output gets a default first, so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_use = 1'b0;
    if (bus.id_valid && ex_slot.memread)
      load_use = (bus.id_use_rs && produces(ex_slot, bus.id_rs)) ||
                 (bus.id_use_rt && produces(ex_slot, bus.id_rt));
  end

  // A taken branch kills the ID instruction, so it overrides a stall.
  assign flush = bus.ex_branch_taken;
  assign stall = load_use && !flush;

  always_comb begin
    fwd_a_nxt = SEL_IDEX;
    fwd_b_nxt = SEL_IDEX;
    if (!stall && !flush) begin
      fwd_a_nxt = pick_src(bus.id_use_rs, bus.id_rs, ex_slot, mem_slot);
      fwd_b_nxt = pick_src(bus.id_use_rt, bus.id_rt, ex_slot, mem_slot);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge, and the shift
  // EX -> MEM does not depend on the order of statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= BUBBLE;
      mem_slot <= BUBBLE;
      fwd_a_q  <= SEL_IDEX;
      fwd_b_q  <= SEL_IDEX;
      state    <= ST_RUN;
    end else begin
      mem_slot <= ex_slot;
      if (stall || flush)
        ex_slot <= BUBBLE;
      else
        ex_slot <= '{valid:    bus.id_valid,
                     rd:       bus.id_rd,
                     regwrite: bus.id_regwrite,
                     memread:  bus.id_memread};
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
      if (flush)      state <= ST_FLUSH;
      else if (stall) state <= ST_STALL;
      else            state <= ST_RUN;
    end
  end

  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.ctrl_state  = state;
  assign bus.pc_hold     = stall;
  assign bus.ifid_hold   = stall;
  assign bus.idex_bubble = stall || flush;
  assign bus.ifid_flush  = flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_ctrl
// Self-checking bench for hazard_forward_ctrl. The driver applies each
// instruction on the falling edge. It asks the reference model what must
// happen and pushes two records: the immediate hold/flush controls and the
// state after the next rising edge. Two monitors pop those records and
// compare them with the DUT.
// ---------------------------------------------------------------------------
module tb_hazard_forward_ctrl;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_ADDR_W(W)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) bus ();

  hazard_forward_ctrl #(.REG_ADDR_W(W)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit       valid;
    bit [4:0] rs, rt, rd;
    bit       use_rs, use_rt, regwrite, memread;
  } instr_t;

  typedef struct {
    bit pc_hold, ifid_hold, idex_bubble, ifid_flush;
  } comb_exp_t;

  typedef struct {
    bit [1:0] sel_a, sel_b, state;
    int       stalls, flushes;
  } reg_exp_t;

  int total = 0;
  int bad   = 0;

  comb_exp_t q_comb[$];
  reg_exp_t  q_reg[$];
  bit        mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The history holds the instructions that entered EX, oldest first. The
  // last entry is the EX instruction and the one before it is in MEM.
  instr_t hist[$];
  int     m_stalls = 0;
  int     m_flushes = 0;

  function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt,
                                int rd, bit rw, bit mr);
    instr_t i;
    i.valid = v; i.rs = rs[4:0]; i.rt = rt[4:0]; i.use_rs = urs;
    i.use_rt = urt; i.rd = rd[4:0]; i.regwrite = rw; i.memread = mr;
    return i;
  endfunction

  function automatic bit writes(instr_t e, bit [4:0] r);
    return e.valid && e.regwrite && e.rd == r && r != 5'd0;
  endfunction

  // Where the newest value of r comes from, as seen by ID: the nearest
  // older producer wins. A load still in EX has no data to give.
  function automatic bit [1:0] source_of(bit use_op, bit [4:0] r);
    instr_t ex, mem;
    ex  = hist[hist.size()-1];
    mem = hist[hist.size()-2];
    if (!use_op) return 2'd0;
    if (writes(ex, r)) begin
      if (!ex.memread) return 2'd2;
    end
    if (writes(mem, r)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    instr_t b;
    b = mk(0, 0, 0, 0, 0, 0, 0, 0);
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    m_stalls = 0;
    m_flushes = 0;
  endtask

  // Applies one ID instruction and branch outcome on a falling edge, then
  // pushes what the model expects.
  task automatic drive(input instr_t i, input bit br, output bit stalled);
    instr_t ex;
    bit hz, st;
    comb_exp_t c;
    reg_exp_t r;
    @(negedge clk);
    bus.id_valid = i.valid;  bus.id_rs = i.rs;  bus.id_rt = i.rt;
    bus.id_use_rs = i.use_rs; bus.id_use_rt = i.use_rt; bus.id_rd = i.rd;
    bus.id_regwrite = i.regwrite; bus.id_memread = i.memread;
    bus.ex_branch_taken = br;
    ex = hist[hist.size()-1];
    hz = i.valid && ex.memread &&
         ((i.use_rs && writes(ex, i.rs)) || (i.use_rt && writes(ex, i.rt)));
    st = hz && !br;
    c.pc_hold = st; c.ifid_hold = st; c.idex_bubble = st || br;
    c.ifid_flush = br;
    if (st) m_stalls++;
    if (br) m_flushes++;
    r.sel_a = (st || br) ? 2'd0 : source_of(i.use_rs, i.rs);
    r.sel_b = (st || br) ? 2'd0 : source_of(i.use_rt, i.rt);
    r.state = br ? 2'd2 : (st ? 2'd1 : 2'd0);
    r.stalls = m_stalls;
    r.flushes = m_flushes;
    q_comb.push_back(c);
    q_reg.push_back(r);
    hist.push_back((st || br) ? mk(0, 0, 0, 0, 0, 0, 0, 0) : i);
    if (hist.size() > 2) void'(hist.pop_front());
    stalled = st;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (q_comb.size() > 0) begin
        comb_exp_t e;
        e = q_comb.pop_front();
        check("pc_hold",     bus.pc_hold,     e.pc_hold);
        check("ifid_hold",   bus.ifid_hold,   e.ifid_hold);
        check("idex_bubble", bus.idex_bubble, e.idex_bubble);
        check("ifid_flush",  bus.ifid_flush,  e.ifid_flush);
      end
    end
  end

  logic [1:0] prev_state = 2'd0;
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (q_reg.size() > 0) begin
        reg_exp_t e;
        e = q_reg.pop_front();
        check("fwd_a_sel",  bus.fwd_a_sel,  e.sel_a);
        check("fwd_b_sel",  bus.fwd_b_sel,  e.sel_b);
        check("ctrl_state", bus.ctrl_state, e.state);
        check("no_stall_stall",
              (prev_state == 2'd1 && bus.ctrl_state == 2'd1), 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", bus.stall_cnt, e.stalls);
        check("flush_cnt", bus.flush_cnt, e.flushes);
`endif
        prev_state = bus.ctrl_state;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  instr_t nop, cur;
  bit     st, br;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0;
    bus.id_use_rt = 0; bus.id_rd = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.ex_branch_taken = 0;
    model_reset();

    // Reset state
    #12;
    check("rst_fwd_a", bus.fwd_a_sel, 2'd0);
    check("rst_fwd_b", bus.fwd_b_sel, 2'd0);
    check("rst_state", bus.ctrl_state, 2'd0);
    check("rst_holds", {bus.pc_hold, bus.ifid_hold, bus.idex_bubble,
                        bus.ifid_flush}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Back-to-back ALU: add r3 then sub rs=r3 gives 10
    drive(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, st);
    drive(mk(1, 3, 2, 1, 1, 8, 1, 0), 0, st);
    drive(nop, 0, st); drive(nop, 0, st);
    // Distance 2: r5 producer, independent, consumer rt=r5 gives 01
    drive(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, st);
    drive(mk(1, 9, 10, 1, 1, 11, 1, 0), 0, st);
    drive(mk(1, 12, 5, 1, 1, 13, 1, 0), 0, st);
    drive(nop, 0, st); drive(nop, 0, st);
    // Double match on r7: the EX/MEM result wins
    drive(mk(1, 1, 2, 1, 1, 7, 1, 0), 0, st);
    drive(mk(1, 1, 2, 1, 1, 7, 1, 0), 0, st);
    drive(mk(1, 7, 2, 1, 0, 14, 1, 0), 0, st);
    drive(nop, 0, st); drive(nop, 0, st);
    // Load-use: lw r4, add rs=r4 stalls once, then forwards from MEM/WB
    drive(mk(1, 1, 0, 1, 0, 4, 1, 1), 0, st);
    drive(mk(1, 4, 2, 1, 1, 15, 1, 0), 0, st);
    drive(mk(1, 4, 2, 1, 1, 15, 1, 0), 0, st);
    drive(nop, 0, st); drive(nop, 0, st);
    // Flush beats a load-use stall in the same cycle
    drive(mk(1, 1, 0, 1, 0, 4, 1, 1), 0, st);
    drive(mk(1, 4, 2, 1, 1, 15, 1, 0), 1, st);
    drive(nop, 0, st); drive(nop, 0, st);
    // Register 0 never forwards or stalls
    drive(mk(1, 1, 0, 1, 0, 0, 1, 1), 0, st);
    drive(mk(1, 0, 0, 1, 1, 16, 1, 0), 0, st);
    drive(mk(1, 0, 0, 1, 1, 17, 1, 0), 0, st);

    // Random traffic. After a stall, ID presents the same instruction again.
    st = 0;
    cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!st) begin
        cur.valid    = ($urandom % 8) != 0;
        cur.rs       = 5'($urandom_range(0, 7));
        cur.rt       = 5'($urandom_range(0, 7));
        cur.rd       = 5'($urandom_range(0, 7));
        cur.use_rs   = ($urandom % 4) != 0;
        cur.use_rt   = ($urandom % 2) != 0;
        cur.regwrite = ($urandom % 4) != 0;
        cur.memread  = cur.regwrite && (($urandom % 3) == 0);
      end
      br = ($urandom % 12) == 0;
      drive(cur, br, st);
    end
    drive(nop, 0, st);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    check("sb_comb_drained", q_comb.size(), 0);
    check("sb_reg_drained",  q_reg.size(), 0);

    // Reset in the middle of a stall: add r6, lw r4 (rs=r6), add rs=r4
    @(negedge clk);
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_use_rs = 1;
    bus.id_use_rt = 0; bus.id_rd = 6; bus.id_regwrite = 1;
    bus.id_memread = 0; bus.ex_branch_taken = 0;
    @(negedge clk);
    bus.id_rs = 6; bus.id_rd = 4; bus.id_memread = 1;
    @(negedge clk);
    bus.id_rs = 4; bus.id_rd = 18; bus.id_memread = 0;
    #2;
    check("pre_rst_pc_hold",   bus.pc_hold, 1'b1);
    check("pre_rst_fwd_a",     bus.fwd_a_sel, 2'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_holds", {bus.pc_hold, bus.ifid_hold, bus.idex_bubble},
          3'd0);
    check("mid_rst_fwd_a", bus.fwd_a_sel, 2'd0);
    check("mid_rst_state", bus.ctrl_state, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("mid_rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 64'd0);
`endif
    bus.id_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", bus.ctrl_state, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Produces the registered 2-bit operand-select codes that drive the EX-stage operand muxes, the load-use stall controls and the taken-branch flush controls.
- Sits beside the ID/EX pipeline register and is clocked with it.

Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, width of the performance counters (only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_ADDR_W  source A register of the ID instruction.
- id_rt  in  REG_ADDR_W  source B register of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- fwd_a_sel  out  2  operand-A select for the EX instruction.
- fwd_b_sel  out  2  operand-B select for the EX instruction.
- pc_hold  out  1  hold the PC.
- ifid_hold  out  1  hold the IF/ID register.
- idex_bubble  out  1  load a bubble into ID/EX.
- ifid_flush  out  1  clear IF/ID to a bubble.
- ctrl_state  out  2  FSM state (debug).

Behaviour:
- Select encoding, fixed:
  - 00 = ID/EX register value (no forward).
  - 01 = MEM/WB result.
  - 10 = EX/MEM result.
  - 11 = reserved, never driven.
- Shadow slots: EX, MEM, WB. Each holds {valid, rd, regwrite, memread}.
- Shadow slot update on every clk:
  - WB <= MEM; MEM <= EX.
  - EX <= ID info when no stall and no flush; otherwise EX <= bubble (valid=0).
- A slot "produces r" when: valid && regwrite && rd == r && r != 0. Register 0 never matches.
- Load-use hazard (combinational), all of:
  - id_valid is high;
  - the EX slot is a producing load (memread=1);
  - its rd matches id_rs with id_use_rs set, or id_rt with id_use_rt set.
- Stall (load-use hazard and not ex_branch_taken):
  - pc_hold = ifid_hold = idex_bubble = 1 for exactly that cycle.
  - Next cycle the load is in MEM and the hazard clears; the stall lasts 1 cycle.
- Flush (ex_branch_taken = 1):
  - ifid_flush = 1 and idex_bubble = 1; pc_hold = ifid_hold = 0.
  - Flush overrides a simultaneous load-use stall.
  - Penalty: 2 bubbles.
- Forward select, computed per operand in ID and registered into fwd_*_sel on the clk edge (valid for the EX instruction):
  - 10 if the EX slot produces the operand register and is not a load.
  - Else 01 if the MEM slot produces it.
  - Else 00.
  - EX/MEM has priority over MEM/WB when both match.
  - An operand not used (id_use_* = 0) always gets 00.
  - On a stall or flush edge, fwd_*_sel <= 00 (a bubble enters EX).
- The register file writes in the first half-cycle; WB-to-ID needs no forwarding.
- FSM (ctrl_state):
  - RUN=0, STALL=1, FLUSH=2.
  - Next state: FLUSH if flush; else STALL if stall; else RUN.
  - Registered; reports the action taken in the previous cycle.
  - STALL→STALL is unreachable; the bench asserts it never occurs.
- Reset (asynchronous, rst_n low): all shadow slots invalid, fwd_a_sel = fwd_b_sel = 00, ctrl_state = RUN, counters 0.
  - pc_hold, ifid_hold, idex_bubble and ifid_flush are combinational and evaluate to 0, since slots are invalid and the reset master gates ex_branch_taken.
  - Reset asserted mid-stall cancels the stall immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt (CNT_W each).
  - stall_cnt increments on each stall cycle; flush_cnt increments on each flush cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- ALU back-to-back: add r3 in ID, then sub using rs=r3 next cycle -> fwd_a_sel=10 in the EX cycle of sub; no stall.
- Distance-2 dependency: producer r5, one independent instruction, consumer rt=r5 -> fwd_b_sel=01.
- Double match: both EX and MEM slots write r7, consumer reads r7 -> fwd_a_sel=10 (priority).
- Load-use: lw r4 in EX, add rs=r4 in ID -> pc_hold/ifid_hold/idex_bubble=1 for exactly 1 cycle, then fwd_a_sel=01; ctrl_state sequence RUN→STALL→RUN.
- Flush vs stall: load-use condition and ex_branch_taken=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_hold=0; ctrl_state=FLUSH; stall_cnt unchanged, flush_cnt +1 (with HAZARD_PERF_CNT_EN).
- Register 0 and reset: a producer writes r0 and a consumer reads r0 -> selects 00, no stall; rst_n pulsed low during a stall -> holds drop at once and selects return to 00.
